// File: rtl/pool2x2_window.sv
// Streaming 2x2 max-pooling window with a half-width line buffer of pair maxima.
// Define POOL_SIGNED_EN to compare pixels as two's-complement signed values.
module pool2x2_window #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              iStart,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iData,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oDone
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int LBN = IMG_W / 2;
  localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVEN = 2'd1;
  localparam logic [1:0] ST_ODD  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic [DATA_W-1:0] max_pix(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
`ifdef POOL_SIGNED_EN
    max_pix = ($signed(a) > $signed(b)) ? a : b;
`else
    max_pix = (a > b) ? a : b;
`endif
  endfunction

  logic [1:0]        state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] pair;
  logic [DATA_W-1:0] lbuf [LBN];

  logic              consume;
  logic              odd_eff;
  logic [CW-1:0]     col_eff;
  logic [RW-1:0]     row_eff;
  logic [LBW-1:0]    lb_idx;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] win_max;
  logic              row_end;
  logic              last_row;
  logic              win_done;

  // A start pulse overrides the live counters so its own pixel lands at (0,0).
  always_comb begin
    consume = iValid && (iStart || (state == ST_EVEN) || (state == ST_ODD));
    if (iStart) begin
      col_eff = '0;
      row_eff = '0;
      odd_eff = 1'b0;
    end else begin
      col_eff = col;
      row_eff = row;
      odd_eff = (state == ST_ODD);
    end
    lb_idx   = LBW'(col_eff >> 1);
    pair_max = max_pix(pair, iData);
    win_max  = max_pix(pair_max, lbuf[lb_idx]);
    row_end  = (col_eff == CW'(IMG_W - 1));
    last_row = (row_eff == RW'(IMG_H - 1));
    win_done = consume && col_eff[0] && odd_eff;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= ST_IDLE;
      col    <= '0;
      row    <= '0;
      pair   <= '0;
      oValid <= 1'b0;
      oData  <= '0;
      oDone  <= 1'b0;
    end else begin
      oDone  <= (state == ST_DONE);
      oValid <= win_done;
      if (win_done) oData <= win_max;
      if (consume && !col_eff[0]) pair <= iData;
      if (iStart) begin
        state <= ST_EVEN;
        row   <= '0;
        col   <= consume ? CW'(1) : '0;
      end else if (consume) begin
        if (row_end) begin
          col <= '0;
          row <= row + RW'(1);
          case (state)
            ST_ODD:  state <= last_row ? ST_DONE : ST_EVEN;
            ST_EVEN: state <= ST_ODD;
            default: state <= ST_IDLE;
          endcase
        end else begin
          col <= col + CW'(1);
        end
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end

  // Line buffer holds don't-care data out of reset, so it has no reset branch.
  always_ff @(posedge aclk) begin
    if (consume && col_eff[0] && !odd_eff) lbuf[lb_idx] <= pair_max;
  end

endmodule

// File: tb/tb_pool2x2_window.sv
// Directed self-checking bench: a 4x2 and a 4x4 instance share one input stream.
module tb_pool2x2_window;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        iStart = 1'b0;
  logic        iValid = 1'b0;
  logic [15:0] iData = 16'h0000;
  logic        va, da, vb, db;
  logic [15:0] dta, dtb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_edge = 0;
  logic [15:0] qa_d[$];
  logic [15:0] qb_d[$];
  int qa_c[$];
  int qa_done[$];
  int qb_done[$];

`ifdef POOL_SIGNED_EN
  localparam logic [15:0] SIGN_EXP = 16'h0002;
`else
  localparam logic [15:0] SIGN_EXP = 16'hFFFD;
`endif

  pool2x2_window #(.DATA_W(16), .IMG_W(4), .IMG_H(2)) dut_a (
    .aclk(aclk), .areset(areset), .iStart(iStart), .iValid(iValid), .iData(iData),
    .oValid(va), .oData(dta), .oDone(da));

  pool2x2_window #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) dut_b (
    .aclk(aclk), .areset(areset), .iStart(iStart), .iValid(iValid), .iData(iData),
    .oValid(vb), .oData(dtb), .oDone(db));

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Record output events half a cycle after each edge.
  always @(negedge aclk) begin
    if (va) begin
      qa_d.push_back(dta);
      qa_c.push_back(cyc);
    end
    if (da) qa_done.push_back(cyc);
    if (vb) qb_d.push_back(dtb);
    if (db) qb_done.push_back(cyc);
  end

  task automatic pix(input logic st, input logic v, input logic [15:0] d);
    iStart = st;
    iValid = v;
    iData  = d;
    @(posedge aclk);
    #1;
    last_edge = cyc;
    iStart = 1'b0;
    iValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) pix(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic clr();
    qa_d.delete(); qa_c.delete(); qa_done.delete();
    qb_d.delete(); qb_done.delete();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    clr();
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({va, dta, da} !== 18'd0) begin errors++; $display("FAIL reset_a got %0h expected 0", {va, dta, da}); end
    checks++; if ({vb, dtb, db} !== 18'd0) begin errors++; $display("FAIL reset_b got %0h expected 0", {vb, dtb, db}); end
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic test_basic();
    int e6;
    int e8;
    do_reset();
    pix(1'b1, 1'b1, 16'd1);
    for (int i = 2; i <= 8; i++) begin
      pix(1'b0, 1'b1, 16'(i));
      if (i == 6) e6 = last_edge;
      if (i == 8) e8 = last_edge;
    end
    idle(4);
    checks++; if (qa_d.size() !== 2) begin errors++; $display("FAIL basic_count got %0d expected 2", qa_d.size()); end
    checks++; if (qa_d[0] !== 16'd6) begin errors++; $display("FAIL basic_d0 got %0d expected 6", qa_d[0]); end
    checks++; if (qa_d[1] !== 16'd8) begin errors++; $display("FAIL basic_d1 got %0d expected 8", qa_d[1]); end
    checks++; if (qa_c[0] !== e6) begin errors++; $display("FAIL basic_lat0 got %0d expected %0d", qa_c[0], e6); end
    checks++; if (qa_c[1] !== e8) begin errors++; $display("FAIL basic_lat1 got %0d expected %0d", qa_c[1], e8); end
    checks++; if (qa_done.size() !== 1) begin errors++; $display("FAIL basic_done_cnt got %0d expected 1", qa_done.size()); end
    checks++; if (qa_done[0] !== e8 + 1) begin errors++; $display("FAIL basic_done_cyc got %0d expected %0d", qa_done[0], e8 + 1); end
  endtask

  task automatic test_gaps();
    int gaps[7] = '{1, 0, 3, 2, 0, 1, 3};
    do_reset();
    pix(1'b1, 1'b1, 16'd1);
    for (int i = 0; i < 7; i++) begin
      idle(gaps[i]);
      pix(1'b0, 1'b1, 16'(i + 2));
    end
    idle(4);
    checks++; if (qa_d.size() !== 2) begin errors++; $display("FAIL gaps_count got %0d expected 2", qa_d.size()); end
    checks++; if (qa_d[0] !== 16'd6 || qa_d[1] !== 16'd8) begin errors++; $display("FAIL gaps_data got %0d,%0d expected 6,8", qa_d[0], qa_d[1]); end
    checks++; if (qa_done.size() !== 1 || qa_done[0] !== qa_c[1] + 1) begin errors++; $display("FAIL gaps_done got n=%0d c=%0d expected n=1 c=%0d", qa_done.size(), qa_done[0], qa_c[1] + 1); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_b[8] = '{16'd6, 16'd8, 16'd14, 16'd16, 16'd16, 16'd14, 16'd8, 16'd6};
    int e16;
    do_reset();
    pix(1'b1, 1'b1, 16'd1);
    for (int i = 2; i <= 16; i++) pix(1'b0, 1'b1, 16'(i));
    e16 = last_edge;
    pix(1'b1, 1'b1, 16'd16);
    for (int i = 15; i >= 1; i--) pix(1'b0, 1'b1, 16'(i));
    idle(4);
    checks++; if (qb_d.size() !== 8) begin errors++; $display("FAIL b2b_count got %0d expected 8", qb_d.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (qb_d[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_d%0d got %0d expected %0d", i, qb_d[i], exp_b[i]); end
    end
    checks++; if (qb_done.size() !== 2) begin errors++; $display("FAIL b2b_done_cnt got %0d expected 2", qb_done.size()); end
    checks++; if (qb_done[0] !== e16 + 1) begin errors++; $display("FAIL b2b_done_cyc got %0d expected %0d", qb_done[0], e16 + 1); end
  endtask

  task automatic test_abandon();
    do_reset();
    pix(1'b1, 1'b1, 16'd1);
    for (int i = 2; i <= 5; i++) pix(1'b0, 1'b1, 16'(i));
    pix(1'b1, 1'b1, 16'd9);
    for (int i = 10; i <= 16; i++) pix(1'b0, 1'b1, 16'(i));
    idle(4);
    checks++; if (qa_d.size() !== 2) begin errors++; $display("FAIL abandon_count got %0d expected 2", qa_d.size()); end
    checks++; if (qa_d[0] !== 16'd14 || qa_d[1] !== 16'd16) begin errors++; $display("FAIL abandon_data got %0d,%0d expected 14,16", qa_d[0], qa_d[1]); end
    checks++; if (qa_done.size() !== 1 || qa_done[0] !== qa_c[1] + 1) begin errors++; $display("FAIL abandon_done got n=%0d c=%0d expected n=1", qa_done.size(), qa_done[0]); end
  endtask

  task automatic test_abandon_pending();
    do_reset();
    pix(1'b1, 1'b1, 16'd1);
    for (int i = 2; i <= 6; i++) pix(1'b0, 1'b1, 16'(i));
    pix(1'b1, 1'b1, 16'd9);
    for (int i = 10; i <= 16; i++) pix(1'b0, 1'b1, 16'(i));
    idle(4);
    checks++; if (qa_d.size() !== 3) begin errors++; $display("FAIL pending_count got %0d expected 3", qa_d.size()); end
    checks++; if (qa_d[0] !== 16'd6 || qa_d[1] !== 16'd14 || qa_d[2] !== 16'd16) begin errors++; $display("FAIL pending_data got %0d,%0d,%0d expected 6,14,16", qa_d[0], qa_d[1], qa_d[2]); end
    checks++; if (qa_done.size() !== 1) begin errors++; $display("FAIL pending_done got %0d expected 1", qa_done.size()); end
  endtask

  task automatic test_signed();
    logic [15:0] px[8] = '{16'hFFFD, 16'h0002, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    do_reset();
    pix(1'b1, 1'b1, px[0]);
    for (int i = 1; i < 8; i++) pix(1'b0, 1'b1, px[i]);
    idle(3);
    checks++; if (qa_d.size() !== 2) begin errors++; $display("FAIL signed_count got %0d expected 2", qa_d.size()); end
    checks++; if (qa_d[0] !== SIGN_EXP) begin errors++; $display("FAIL signed_max got %0h expected %0h", qa_d[0], SIGN_EXP); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pix(1'b1, 1'b1, 16'd1);
    for (int i = 2; i <= 6; i++) pix(1'b0, 1'b1, 16'(i));
    checks++; if (va !== 1'b1 || dta !== 16'd6) begin errors++; $display("FAIL arst_pre got v=%0b d=%0d expected v=1 d=6", va, dta); end
    areset = 1'b1;
    #1;
    checks++; if ({va, dta, da} !== 18'd0) begin errors++; $display("FAIL arst_outputs got %0h expected 0", {va, dta, da}); end
    @(posedge aclk);
    #1;
    areset = 1'b0;
    clr();
    for (int i = 0; i < 8; i++) pix(1'b0, 1'b1, 16'(50 + i));
    idle(3);
    checks++; if (qa_d.size() !== 0 || qa_done.size() !== 0) begin errors++; $display("FAIL arst_nostart got v=%0d d=%0d expected 0,0", qa_d.size(), qa_done.size()); end
    pix(1'b1, 1'b1, 16'd1);
    for (int i = 2; i <= 8; i++) pix(1'b0, 1'b1, 16'(i));
    idle(4);
    checks++; if (qa_d.size() !== 2 || qa_d[0] !== 16'd6 || qa_d[1] !== 16'd8) begin errors++; $display("FAIL arst_frame got n=%0d %0d,%0d expected n=2 6,8", qa_d.size(), qa_d[0], qa_d[1]); end
    checks++; if (qa_done.size() !== 1) begin errors++; $display("FAIL arst_done got %0d expected 1", qa_done.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_abandon();
    test_abandon_pending();
    test_signed();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
